sr_ff_driver: RTL

//   Initiator side of the sr_flipflop s/r interface.

---
 rtl/sr_ff_driver.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sr_ff_driver.sv
// sr_ff_driver: initiator for an sr_flipflop s/r interface.
// Each accepted command becomes a one-cycle s/r pulse. The driver then watches
// q/q_bar until the flop reaches the requested state, and reports done or err.
//
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE and depends only on
// the state. cmd_valid may be held high across commands. A command that is
// waiting when the driver returns to IDLE is taken on the very next edge.
module sr_ff_driver #(
    parameter int TIMEOUT = 4,   // max WAIT cycles before a timeout error (1..255)
    parameter int CNT_W   = 8    // width of pass_cnt / fail_cnt
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic             cmd_bit,
    output logic             cmd_ready,
    output logic             s,
    output logic             r,
    input  logic             q,
    input  logic             q_bar,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_ILLEGAL = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT = 2'd2;

    state_t     state;
    logic       tgt;
    logic [7:0] wait_cnt;

    // Ready is a pure function of state, so it never depends on cmd_valid.
    assign cmd_ready = (state == ST_IDLE);

    // Command FSM. s/r, done, err and the counters are all registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            tgt      <= 1'b0;
            wait_cnt <= 8'd0;
            s        <= 1'b0;
            r        <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= CODE_NONE;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            // The pulse outputs default low. s and r are raised only on the
            // edge that enters DRIVE. There they are complementary, so s=r=1
            // can never be driven.
            s    <= 1'b0;
            r    <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        tgt      <= cmd_bit;
                        s        <= cmd_bit;
                        r        <= ~cmd_bit;
                        err_code <= CODE_NONE;
                        state    <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // The flop captures s/r on this edge. Its response is
                    // first sampled on the next edge.
                    wait_cnt <= 8'd0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (q == q_bar) begin
                        err      <= 1'b1;
                        err_code <= CODE_ILLEGAL;
                        if (fail_cnt != {CNT_W{1'b1}}) begin
                            fail_cnt <= fail_cnt + 1'b1;
                        end
                        state    <= ST_ERR;
                    end else if ((q == tgt) && (q_bar == ~tgt)) begin
                        done     <= 1'b1;
                        pass_cnt <= pass_cnt + 1'b1;
                        state    <= ST_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err      <= 1'b1;
                        err_code <= CODE_TIMEOUT;
                        if (fail_cnt != {CNT_W{1'b1}}) begin
                            fail_cnt <= fail_cnt + 1'b1;
                        end
                        state    <= ST_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
